// File: rtl/paralelo_serial_tx_if.sv
// Parallel byte handshake between an upstream source and paralelo_serial_tx.
// The transmitter samples data_in/valid_in only in the cycle where it drives ready.
interface paralelo_serial_tx_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready;

    modport master (output data_in, output valid_in, input ready);
    modport slave  (input data_in, input valid_in, output ready);
endinterface

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: sends SYNC_COUNT comma bytes after reset, then streams bytes MSB first.
// Optional macro PARALELO_SERIAL_BYTE_COUNT_EN adds the tx_count output counting accepted data bytes.
module paralelo_serial_tx #(
    parameter logic [7:0]  COM_SYMBOL = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    paralelo_serial_tx_if.slave  bus,
    output logic                 data_out,
    output logic                 active
`ifdef PARALELO_SERIAL_BYTE_COUNT_EN
    ,
    output logic [15:0]          tx_count
`endif
);
    localparam int unsigned SYNC_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COUNT - 1);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        bit_cnt;
    logic [7:0]        cur_byte;
    logic [SYNC_W-1:0] sync_cnt;
    logic              byte_end;
    logic              take_data;

    assign byte_end  = (bit_cnt == 3'd7);
    assign take_data = bus.ready && bus.valid_in;

    // State register
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the combinational sample strobe
    always_comb begin
        state_next = state;
        bus.ready  = 1'b0;
        case (state)
            SYNC: begin
                if (byte_end && (sync_cnt == SYNC_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.ready = byte_end;
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    // Serializer: free-running bit counter, next byte loaded on the last bit of the current one
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= 3'd0;
            cur_byte <= COM_SYMBOL;
            data_out <= 1'b0;
            sync_cnt <= '0;
            active   <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            data_out <= cur_byte[3'd7 - bit_cnt];
            active   <= (state_next == RUN);
            if (byte_end) begin
                cur_byte <= take_data ? bus.data_in : COM_SYMBOL;
            end
            if ((state == SYNC) && byte_end) begin
                sync_cnt <= sync_cnt + SYNC_W'(1);
            end
        end
    end

`ifdef PARALELO_SERIAL_BYTE_COUNT_EN
    // Accepted data bytes; wraps naturally at 16 bits
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            tx_count <= 16'd0;
        end else if (take_data) begin
            tx_count <= tx_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: sync preamble, single and back-to-back bytes,
// ready-edge-only sampling, mid-byte reset and (with the macro) the byte counter.
module tb_paralelo_serial_tx;
    localparam logic [7:0] COM = 8'hBC;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        data_out;
    logic        active;
`ifdef PARALELO_SERIAL_BYTE_COUNT_EN
    logic [15:0] tx_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    paralelo_serial_tx_if bus ();

    paralelo_serial_tx #(
        .COM_SYMBOL (COM),
        .SYNC_COUNT (4)
    ) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .bus      (bus),
        .data_out (data_out),
        .active   (active)
`ifdef PARALELO_SERIAL_BYTE_COUNT_EN
        ,
        .tx_count (tx_count)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic wait_ready(output bit found);
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found) begin
                if (bus.ready === 1'b1) found = 1'b1;
                else tick();
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({data_out, active, bus.ready} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got data_out/active/ready=%b want 000",
                     {data_out, active, bus.ready});
        end
    endtask

    task automatic test_sync();
        logic [7:0] com_v = COM;
        logic exp_bit, exp_act, exp_rdy;
        @(negedge clk_32f);
        reset = 1'b1;
        for (int e = 1; e <= 48; e++) begin
            tick();
            exp_bit = com_v[7 - ((e - 1) % 8)];
            exp_act = (e >= 32);
            exp_rdy = (e >= 32) && (e % 8 == 7);
            n_cmp++;
            if ({data_out, active, bus.ready} !== {exp_bit, exp_act, exp_rdy}) begin
                n_err++;
                $display("FAIL sync_edge%0d: got data_out/active/ready=%b want %b",
                         e, {data_out, active, bus.ready}, {exp_bit, exp_act, exp_rdy});
            end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] com_v = COM;
        logic [7:0] b = 8'hA5;
        logic exp_bit;
        bit found;
        wait_ready(found);
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL single_ready: got no ready within 16 cycles want ready");
        end
        bus.data_in  = b;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_bit = (i < 8) ? b[7 - i] : com_v[15 - i];
            n_cmp++;
            if (data_out !== exp_bit) begin
                n_err++;
                $display("FAIL single_bit%0d: got %b want %b", i, data_out, exp_bit);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] stream = {8'hFF, 8'h00, 8'h3C};
        logic [7:0]  bytes [3] = '{8'hFF, 8'h00, 8'h3C};
        bit found;
        wait_ready(found);
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL b2b_ready: got no ready within 16 cycles want ready");
        end
        for (int k = 0; k <= 24; k++) begin
            if (k % 8 == 0) begin
                n_cmp++;
                if (bus.ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready_slot%0d: got %b want 1", k / 8, bus.ready);
                end
                if (k < 24) begin
                    bus.data_in  = bytes[k / 8];
                    bus.valid_in = 1'b1;
                end else begin
                    bus.data_in  = 8'h00;
                    bus.valid_in = 1'b0;
                end
            end
            tick();
            if (k >= 1) begin
                n_cmp++;
                if (data_out !== stream[24 - k]) begin
                    n_err++;
                    $display("FAIL b2b_bit%0d: got %b want %b", k - 1, data_out, stream[24 - k]);
                end
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_ignore_nonready();
        logic [23:0] stream = {8'hBC, 8'hBC, 8'h5A};
        logic [7:0]  bytes [3] = '{8'hBC, 8'hFF, 8'h5A};
        logic        vals [3]  = '{1'b1, 1'b0, 1'b1};
        bit found;
        wait_ready(found);
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL ignore_ready: got no ready within 16 cycles want ready");
        end
        for (int k = 0; k <= 24; k++) begin
            if (k % 8 == 0) begin
                if (k < 24) begin
                    bus.data_in  = bytes[k / 8];
                    bus.valid_in = vals[k / 8];
                end else begin
                    bus.data_in  = 8'h00;
                    bus.valid_in = 1'b0;
                end
            end else begin
                bus.data_in  = 8'(k * 37 + 1);
                bus.valid_in = 1'b1;
            end
            tick();
            if (k >= 1) begin
                n_cmp++;
                if (data_out !== stream[24 - k]) begin
                    n_err++;
                    $display("FAIL ignore_bit%0d: got %b want %b", k - 1, data_out, stream[24 - k]);
                end
            end
        end
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
    endtask

    task automatic test_reset_midbyte();
        logic [7:0] com_v = COM;
        logic [7:0] b = 8'hC3;
        logic exp_bit, exp_act, exp_rdy;
        bit found;
        wait_ready(found);
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL midrst_ready: got no ready within 16 cycles want ready");
        end
        bus.data_in  = b;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (data_out !== b[7 - i]) begin
                n_err++;
                $display("FAIL midrst_pre_bit%0d: got %b want %b", i, data_out, b[7 - i]);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({data_out, active, bus.ready} !== 3'b000) begin
            n_err++;
            $display("FAIL midrst_async: got data_out/active/ready=%b want 000",
                     {data_out, active, bus.ready});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({data_out, active, bus.ready} !== 3'b000) begin
                n_err++;
                $display("FAIL midrst_hold%0d: got data_out/active/ready=%b want 000",
                         i, {data_out, active, bus.ready});
            end
        end
        @(negedge clk_32f);
        reset = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp_bit = com_v[7 - ((e - 1) % 8)];
            exp_act = (e >= 32);
            exp_rdy = (e >= 32) && (e % 8 == 7);
            n_cmp++;
            if ({data_out, active, bus.ready} !== {exp_bit, exp_act, exp_rdy}) begin
                n_err++;
                $display("FAIL midrst_edge%0d: got data_out/active/ready=%b want %b",
                         e, {data_out, active, bus.ready}, {exp_bit, exp_act, exp_rdy});
            end
        end
    endtask

`ifdef PARALELO_SERIAL_BYTE_COUNT_EN
    task automatic test_byte_count();
        logic [7:0] pat = 8'b10101101;
        bit found;
        n_cmp++;
        if (tx_count !== 16'd0) begin
            n_err++;
            $display("FAIL count_after_reset: got %0d want 0", tx_count);
        end
        for (int s = 0; s < 8; s++) begin
            wait_ready(found);
            n_cmp++;
            if (!found) begin
                n_err++;
                $display("FAIL count_ready%0d: got no ready within 16 cycles want ready", s);
            end
            bus.data_in  = 8'(s + 16);
            bus.valid_in = pat[s];
            tick();
            bus.valid_in = 1'b0;
        end
        n_cmp++;
        if (tx_count !== 16'd5) begin
            n_err++;
            $display("FAIL count_interleaved: got %0d want 5", tx_count);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        test_reset();
        test_sync();
        test_single_byte();
        test_back_to_back();
        test_ignore_nonready();
        test_reset_midbyte();
`ifdef PARALELO_SERIAL_BYTE_COUNT_EN
        test_byte_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/paralelo_serial_tx.md
PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 Parameter: COM_SYMBOL, default 8'hBC, idle/comma byte transmitted when no valid data is offered.
REQ-002 Parameter: SYNC_COUNT, default 4, number of COM bytes sent after reset before data is accepted.
REQ-003 clk_32f  input  1  bit clock; all state changes on the rising edge; one serial bit per cycle.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  8  parallel byte offered by the upstream source.
REQ-006 valid_in  input  1  data_in holds a real data byte.
REQ-007 ready  output  1  high for exactly the one cycle in which data_in/valid_in are sampled.
REQ-008 data_out  output  1  registered serial output, MSB first, feeding serial_paralelo data_in.
REQ-009 active  output  1  high once the SYNC phase is complete.

Function
REQ-010 A 3-bit bit counter bit_cnt shall increment by 1 every cycle and wrap 7 -> 0 without a gap.
REQ-011 Each cycle: data_out <= cur_byte[7 - bit_cnt], giving MSB-first order, 8 cycles per byte.
REQ-012 On the edge where bit_cnt == 7, cur_byte shall load the next byte: data_in if (state RUN and valid_in == 1), else COM_SYMBOL.
REQ-013 ready = 1 combinationally when bit_cnt == 7 and state == RUN; 0 otherwise.
REQ-014 data_in/valid_in shall be ignored on every edge other than the ready edge; the source holds them stable through it.
REQ-015 Latency: a byte sampled on edge E drives its bit 7 on data_out after edge E+1 and its bit 0 after edge E+8.
REQ-016 States: SYNC and RUN; SYNC is entered on reset.
REQ-017 SYNC: ready = 0, active = 0, only COM_SYMBOL bytes are transmitted, and a byte counter counts completed COM bytes.
REQ-018 SYNC -> RUN on the edge where bit_cnt == 7 and the SYNC_COUNT-th COM byte finishes; that same edge loads COM_SYMBOL.
REQ-019 RUN: active = 1; the state stays in RUN until reset.
REQ-020 RUN with valid_in == 0 at the ready edge: COM_SYMBOL is inserted in that slot; no byte is dropped or repeated.
REQ-021 Back-to-back valid bytes shall be transmitted contiguously with no idle bits between them.
REQ-022 A data byte equal to COM_SYMBOL shall be transmitted unchanged; no escaping is performed.

Reset
REQ-023 When reset == 0, the block shall immediately set data_out = 0, bit_cnt = 0, cur_byte = COM_SYMBOL, state = SYNC, SYNC counter = 0, active = 0, and ready = 0.
REQ-024 Reset asserted mid-byte shall abort the byte; after release, transmission restarts with a full COM byte, bit 7 first.
REQ-025 The first edge after reset release shall output cur_byte[7], which is 1 for 8'hBC.

Configuration
REQ-026 Macro PARALELO_SERIAL_BYTE_COUNT_EN: when defined, adds the output tx_count [15:0].
- tx_count increments on each RUN ready edge with valid_in == 1.
- tx_count wraps 16'hFFFF -> 0 and resets to 0.
REQ-027 When PARALELO_SERIAL_BYTE_COUNT_EN is undefined, the port and the counter shall not exist; all other behaviour is identical.

Verification
REQ-028 Reset release with valid_in = 0 for 48 cycles -> data_out = 1,0,1,1,1,1,0,0 repeated 6 times; active rises after edge 32; first ready at cycle 40.
REQ-029 After sync, present 8'hA5 with valid_in = 1 at the ready edge -> next 8 bits = 1,0,1,0,0,1,0,1, then a COM byte.
REQ-030 Bytes 8'hFF, 8'h00, 8'h3C presented on consecutive ready edges -> 24 contiguous bits 8x1, 8x0, 00111100.
REQ-031 Reset pulsed low for 3 cycles during bit 4 of a data byte -> data_out = 0 during reset, active = 0; after release, full COM sequence and 4-byte SYNC repeat.
REQ-032 Change data_in/valid_in on non-ready cycles -> serial stream unaffected; only ready-edge values are transmitted.
REQ-033 With PARALELO_SERIAL_BYTE_COUNT_EN, send 5 valid bytes interleaved with 3 idle slots -> tx_count = 5; preload near 16'hFFFF via 65536 bytes -> wraps to 0.
